// File: rtl/sram_1rw1r_ctrl.sv
// sram_1rw1r_ctrl: initiator for a 1RW1R SRAM: port-0 request channel, port-1 burst reader.
// Define SRAM_CTRL_COLLISION_STALL_EN to hold off port-1 issue on a same-address port-0 write.
module sram_1rw1r_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 9,
  parameter int NUM_WMASKS = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [NUM_WMASKS-1:0] req_wmask,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  input  logic                  strm_start,
  input  logic [ADDR_WIDTH-1:0] strm_base,
  input  logic [ADDR_WIDTH:0]   strm_len,
  output logic                  strm_busy,
  output logic                  strm_done,
  output logic                  strm_valid,
  input  logic                  strm_ready,
  output logic [DATA_WIDTH-1:0] strm_data,
  output logic                  sram_csb0,
  output logic                  sram_web0,
  output logic [NUM_WMASKS-1:0] sram_wmask0,
  output logic [ADDR_WIDTH-1:0] sram_addr0,
  output logic [DATA_WIDTH-1:0] sram_din0,
  input  logic [DATA_WIDTH-1:0] sram_dout0,
  output logic                  sram_csb1,
  output logic [ADDR_WIDTH-1:0] sram_addr1,
  input  logic [DATA_WIDTH-1:0] sram_dout1
);

  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = 1;
  localparam logic [ADDR_WIDTH:0]   LEN_ONE  = 1;

  typedef enum logic [1:0] {
    P0_IDLE,
    P0_CAPT,
    P0_RESP
  } p0_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN
  } s_e;

  p0_e                   p0_q;
  logic                  req_ready_q;
  logic                  rsp_valid_q;
  logic [DATA_WIDTH-1:0] rsp_rdata_q;

  logic req_fire;
  logic wr_fire;

  assign req_fire = req_valid & req_ready_q;
  assign wr_fire  = req_fire & req_we;

  assign req_ready   = req_ready_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;

  assign sram_csb0   = ~req_fire;
  assign sram_web0   = ~wr_fire;
  assign sram_wmask0 = wr_fire ? req_wmask : '0;
  assign sram_addr0  = req_fire ? req_addr : '0;
  assign sram_din0   = wr_fire ? req_wdata : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p0_q        <= P0_IDLE;
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      unique case (p0_q)
        P0_IDLE: begin
          req_ready_q <= 1'b1;
          if (req_fire && !req_we) begin
            req_ready_q <= 1'b0;
            p0_q        <= P0_CAPT;
          end
        end
        P0_CAPT: begin
          rsp_rdata_q <= sram_dout0;
          rsp_valid_q <= 1'b1;
          p0_q        <= P0_RESP;
        end
        P0_RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            req_ready_q <= 1'b1;
            p0_q        <= P0_IDLE;
          end
        end
        default: p0_q <= P0_IDLE;
      endcase
    end
  end

  s_e                    s_q;
  logic [ADDR_WIDTH-1:0] saddr_q;
  logic [ADDR_WIDTH:0]   remain_q;
  logic                  inflight_q;
  logic [DATA_WIDTH-1:0] buf_q [2];
  logic                  wptr_q;
  logic                  rptr_q;
  logic [1:0]            cnt_q;
  logic                  busy_q;
  logic                  done_q;

  logic       pop;
  logic       collide;
  logic       issue;
  logic [2:0] occ;

`ifdef SRAM_CTRL_COLLISION_STALL_EN
  assign collide = wr_fire & (req_addr == saddr_q);
`else
  assign collide = 1'b0;
`endif

  // Occupancy after this cycle's pop keeps full rate yet never overfills the buffer.
  assign pop   = (cnt_q != 2'd0) & strm_ready;
  assign occ   = {1'b0, cnt_q} + {2'b0, inflight_q} - {2'b0, pop};
  assign issue = (s_q == S_RUN) && (remain_q != '0)
              && (occ < 3'd2) && !collide;

  assign sram_csb1  = ~issue;
  assign sram_addr1 = issue ? saddr_q : '0;

  assign strm_busy  = busy_q;
  assign strm_done  = done_q;
  assign strm_valid = cnt_q != 2'd0;
  assign strm_data  = buf_q[rptr_q];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_q        <= S_IDLE;
      saddr_q    <= '0;
      remain_q   <= '0;
      inflight_q <= 1'b0;
      buf_q[0]   <= '0;
      buf_q[1]   <= '0;
      wptr_q     <= 1'b0;
      rptr_q     <= 1'b0;
      cnt_q      <= 2'd0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q     <= 1'b0;
      inflight_q <= issue;
      cnt_q      <= cnt_q + {1'b0, inflight_q} - {1'b0, pop};
      if (inflight_q) begin
        buf_q[wptr_q] <= sram_dout1;
        wptr_q        <= ~wptr_q;
      end
      if (pop) rptr_q <= ~rptr_q;
      if (issue) begin
        saddr_q  <= saddr_q + ADDR_ONE;
        remain_q <= remain_q - LEN_ONE;
      end
      unique case (s_q)
        S_IDLE: begin
          if (strm_start) begin
            if (strm_len != '0) begin
              saddr_q  <= strm_base;
              remain_q <= strm_len;
              busy_q   <= 1'b1;
              s_q      <= S_RUN;
            end else begin
              done_q <= 1'b1;
            end
          end
        end
        S_RUN: begin
          if (issue && remain_q == LEN_ONE) s_q <= S_DRAIN;
        end
        S_DRAIN: begin
          if (pop && cnt_q == 2'd1 && !inflight_q) begin
            done_q <= 1'b1;
            busy_q <= 1'b0;
            s_q    <= S_IDLE;
          end
        end
        default: s_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_1rw1r_ctrl.sv
// tb_sram_1rw1r_ctrl: directed bench for sram_1rw1r_ctrl with a behavioural 1RW1R SRAM.
// Stream traffic is recorded by a monitor one time unit after each falling edge.
module tb_sram_1rw1r_ctrl;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [3:0]  req_wmask;
  logic [8:0]  req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        strm_start;
  logic [8:0]  strm_base;
  logic [9:0]  strm_len;
  logic        strm_busy;
  logic        strm_done;
  logic        strm_valid;
  logic        strm_ready;
  logic [31:0] strm_data;
  logic        sram_csb0;
  logic        sram_web0;
  logic [3:0]  sram_wmask0;
  logic [8:0]  sram_addr0;
  logic [31:0] sram_din0;
  logic [31:0] sram_dout0;
  logic        sram_csb1;
  logic [8:0]  sram_addr1;
  logic [31:0] sram_dout1;

  int n_cmp = 0;
  int n_bad = 0;

  sram_1rw1r_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_wmask  (req_wmask),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_rdata  (rsp_rdata),
    .strm_start (strm_start),
    .strm_base  (strm_base),
    .strm_len   (strm_len),
    .strm_busy  (strm_busy),
    .strm_done  (strm_done),
    .strm_valid (strm_valid),
    .strm_ready (strm_ready),
    .strm_data  (strm_data),
    .sram_csb0  (sram_csb0),
    .sram_web0  (sram_web0),
    .sram_wmask0(sram_wmask0),
    .sram_addr0 (sram_addr0),
    .sram_din0  (sram_din0),
    .sram_dout0 (sram_dout0),
    .sram_csb1  (sram_csb1),
    .sram_addr1 (sram_addr1),
    .sram_dout1 (sram_dout1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural SRAM: inputs registered at the rising edge, data out by the next one.
  logic [31:0] mem [512];

  initial begin
    sram_dout0 = '0;
    sram_dout1 = '0;
    for (int i = 0; i < 512; i++) mem[i] = '0;
  end

  always @(posedge clk) begin
    if (!sram_csb0) begin
      if (!sram_web0) begin
        for (int b = 0; b < 4; b++)
          if (sram_wmask0[b]) mem[sram_addr0][b*8 +: 8] <= sram_din0[b*8 +: 8];
      end else begin
        sram_dout0 <= mem[sram_addr0];
      end
    end
    if (!sram_csb1) sram_dout1 <= mem[sram_addr1];
  end

  // Stream monitor with its own occupancy model.
  int          cyc = 0;
  int          iss_n = 0;
  int          done_n = 0;
  int          rsp_n = 0;
  int          cnt_m = 0;
  int          infl_m = 0;
  int          occ_m;
  int          pop_m;
  logic [31:0] got_d [$];
  int          got_c [$];
  int          done_c [$];

  always begin
    @(negedge clk);
    #1;
    cyc++;
    if (rst) begin
      cnt_m  = 0;
      infl_m = 0;
    end else begin
      pop_m = (strm_valid && strm_ready) ? 1 : 0;
      occ_m = cnt_m + infl_m - pop_m;
      if (sram_csb1 === 1'b0) begin
        iss_n++;
        n_cmp++;
        if (occ_m >= 2) begin
          n_bad++;
          $display("FAIL occupancy: issue with occupancy %0d, required below 2", occ_m);
        end
      end
      if (pop_m == 1) begin
        got_d.push_back(strm_data);
        got_c.push_back(cyc);
      end
      if (strm_done === 1'b1) begin
        done_n++;
        done_c.push_back(cyc);
      end
      if (rsp_valid === 1'b1) rsp_n++;
      cnt_m  = cnt_m + infl_m - pop_m;
      infl_m = (sram_csb1 === 1'b0) ? 1 : 0;
    end
  end

  task automatic clear_mon();
    got_d.delete();
    got_c.delete();
    done_c.delete();
    done_n = 0;
  endtask

  task automatic do_write(input logic [8:0] a, input logic [31:0] d,
                          input logic [3:0] m);
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_addr  = a;
    req_wdata = d;
    req_wmask = m;
    @(negedge clk);
    req_valid = 1'b0;
    req_we    = 1'b0;
  endtask

  task automatic do_read(input logic [8:0] a, output logic [31:0] d,
                         output int lat);
    lat = -1;
    d   = '0;
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_addr  = a;
    rsp_ready = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      req_valid = 1'b0;
      if (rsp_valid === 1'b1 && lat < 0) begin
        lat = k;
        d   = rsp_rdata;
      end
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    #1;
    n_cmp++;
    if (req_ready !== 1'b0 || rsp_valid !== 1'b0 || rsp_rdata !== 32'h0) begin
      n_bad++;
      $display("FAIL rst_p0: ready=%b valid=%b data=%h, required 0/0/0",
               req_ready, rsp_valid, rsp_rdata);
    end
    n_cmp++;
    if (strm_busy !== 1'b0 || strm_done !== 1'b0 || strm_valid !== 1'b0
        || strm_data !== 32'h0) begin
      n_bad++;
      $display("FAIL rst_strm: busy=%b done=%b valid=%b data=%h, required 0/0/0/0",
               strm_busy, strm_done, strm_valid, strm_data);
    end
    n_cmp++;
    if (sram_csb0 !== 1'b1 || sram_web0 !== 1'b1 || sram_wmask0 !== 4'h0
        || sram_addr0 !== 9'h0 || sram_din0 !== 32'h0) begin
      n_bad++;
      $display("FAIL rst_port0: csb=%b web=%b wm=%h a=%h din=%h, required 1/1/0/0/0",
               sram_csb0, sram_web0, sram_wmask0, sram_addr0, sram_din0);
    end
    n_cmp++;
    if (sram_csb1 !== 1'b1 || sram_addr1 !== 9'h0) begin
      n_bad++;
      $display("FAIL rst_port1: csb1=%b a1=%h, required 1/0", sram_csb1, sram_addr1);
    end
    rst = 1'b0;
    @(negedge clk);
    #1;
    n_cmp++;
    if (req_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL rst_release_ready: got %b, required 1", req_ready);
    end
  endtask

  task automatic test_write_read();
    do_write(9'h010, 32'hDEADBEEF, 4'hF);
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_addr  = 9'h010;
    rsp_ready = 1'b1;
    #1;
    n_cmp++;
    if (sram_csb0 !== 1'b0 || sram_web0 !== 1'b1 || sram_addr0 !== 9'h010) begin
      n_bad++;
      $display("FAIL rd_drive: csb0=%b web0=%b a0=%h, required 0/1/010",
               sram_csb0, sram_web0, sram_addr0);
    end
    @(negedge clk);
    req_valid = 1'b0;
    n_cmp++;
    if (req_ready !== 1'b0 || rsp_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL rd_capt: ready=%b valid=%b, required 0/0", req_ready, rsp_valid);
    end
    @(negedge clk);
    n_cmp++;
    if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hDEADBEEF) begin
      n_bad++;
      $display("FAIL rd_rsp: valid=%b data=%h, required 1/deadbeef", rsp_valid, rsp_rdata);
    end
    @(negedge clk);
    n_cmp++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL rd_done: valid=%b ready=%b, required 0/1", rsp_valid, req_ready);
    end
  endtask

  task automatic test_mask();
    logic [31:0] d;
    int          lat;
    do_write(9'h020, 32'hAAAAAAAA, 4'hF);
    do_write(9'h020, 32'h11223344, 4'b0101);
    do_read(9'h020, d, lat);
    n_cmp++;
    if (d !== 32'hAA22AA44) begin
      n_bad++;
      $display("FAIL mask_data: got %h, required aa22aa44", d);
    end
    n_cmp++;
    if (lat !== 2) begin
      n_bad++;
      $display("FAIL mask_latency: got %0d, required 2", lat);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      req_valid = 1'b1;
      req_we    = 1'b1;
      req_wmask = 4'hF;
      req_addr  = 9'(9'h030 + i);
      req_wdata = 32'h000000A0 + i;
      #1;
      n_cmp++;
      if (req_ready !== 1'b1 || sram_csb0 !== 1'b0) begin
        n_bad++;
        $display("FAIL b2b_accept%0d: ready=%b csb0=%b, required 1/0",
                 i, req_ready, sram_csb0);
      end
    end
    @(negedge clk);
    req_valid = 1'b0;
    req_we    = 1'b0;
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (mem[9'(9'h030 + i)] !== 32'h000000A0 + i) begin
        n_bad++;
        $display("FAIL b2b_mem%0d: got %h, required %h",
                 i, mem[9'(9'h030 + i)], 32'h000000A0 + i);
      end
    end
  endtask

  task automatic test_rsp_backpressure();
    do_write(9'h040, 32'h0BADF00D, 4'hF);
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_addr  = 9'h040;
    rsp_ready = 1'b0;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      n_cmp++;
      if (rsp_valid !== 1'b1 || req_ready !== 1'b0 || rsp_rdata !== 32'h0BADF00D) begin
        n_bad++;
        $display("FAIL bp_hold%0d: valid=%b ready=%b data=%h, required 1/0/0badf00d",
                 k, rsp_valid, req_ready, rsp_rdata);
      end
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL bp_release: valid=%b ready=%b, required 0/1", rsp_valid, req_ready);
    end
  endtask

  task automatic test_stream_full();
    int c0;
    logic [31:0] exp_d [4];
    exp_d = '{32'h1FE, 32'h1FF, 32'h000, 32'h001};
    for (int i = 0; i < 512; i++) mem[i] = i;
    clear_mon();
    strm_ready = 1'b1;
    @(negedge clk);
    strm_start = 1'b1;
    strm_base  = 9'h1FE;
    strm_len   = 10'd4;
    #2;
    c0 = cyc;
    @(negedge clk);
    strm_start = 1'b0;
    #2;
    n_cmp++;
    if (strm_busy !== 1'b1 || sram_csb1 !== 1'b0 || sram_addr1 !== 9'h1FE) begin
      n_bad++;
      $display("FAIL sf_start: busy=%b csb1=%b a1=%h, required 1/0/1fe",
               strm_busy, sram_csb1, sram_addr1);
    end
    repeat (10) @(negedge clk);
    #2;
    n_cmp++;
    if (got_d.size() !== 4) begin
      n_bad++;
      $display("FAIL sf_count: got %0d words, required 4", got_d.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_cmp++;
        if (got_d[i] !== exp_d[i] || got_c[i] !== c0 + 3 + i) begin
          n_bad++;
          $display("FAIL sf_word%0d: data %h at cycle +%0d, required %h at +%0d",
                   i, got_d[i], got_c[i] - c0, exp_d[i], 3 + i);
        end
      end
    end
    n_cmp++;
    if (done_n !== 1 || done_c.size() == 0 || done_c[0] !== c0 + 7) begin
      n_bad++;
      $display("FAIL sf_done: %0d pulses, first at +%0d, required 1 at +7",
               done_n, (done_c.size() == 0) ? -1 : done_c[0] - c0);
    end
    n_cmp++;
    if (strm_busy !== 1'b0 || strm_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL sf_idle: busy=%b valid=%b, required 0/0", strm_busy, strm_valid);
    end
  endtask

  task automatic test_stream_toggle();
    logic [31:0] exp_d [4];
    exp_d = '{32'h1FE, 32'h1FF, 32'h000, 32'h001};
    clear_mon();
    @(negedge clk);
    strm_start = 1'b1;
    strm_base  = 9'h1FE;
    strm_len   = 10'd4;
    strm_ready = 1'b1;
    for (int k = 0; k < 24; k++) begin
      @(negedge clk);
      strm_start = (k == 2);
      strm_base  = (k == 2) ? 9'h100 : 9'h1FE;
      strm_len   = (k == 2) ? 10'd2 : 10'd4;
      strm_ready = ~strm_ready;
    end
    strm_start = 1'b0;
    strm_ready = 1'b1;
    repeat (4) @(negedge clk);
    #2;
    n_cmp++;
    if (got_d.size() !== 4) begin
      n_bad++;
      $display("FAIL st_count: got %0d words, required 4", got_d.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_cmp++;
        if (got_d[i] !== exp_d[i]) begin
          n_bad++;
          $display("FAIL st_word%0d: got %h, required %h", i, got_d[i], exp_d[i]);
        end
      end
    end
    n_cmp++;
    if (done_n !== 1 || strm_busy !== 1'b0) begin
      n_bad++;
      $display("FAIL st_done: %0d pulses busy=%b, required 1/0", done_n, strm_busy);
    end
  endtask

  task automatic test_len_zero();
    int iss0;
    clear_mon();
    iss0 = iss_n;
    @(negedge clk);
    strm_start = 1'b1;
    strm_base  = 9'h055;
    strm_len   = 10'd0;
    @(negedge clk);
    strm_start = 1'b0;
    #2;
    n_cmp++;
    if (strm_done !== 1'b1 || strm_busy !== 1'b0) begin
      n_bad++;
      $display("FAIL len0_done: done=%b busy=%b, required 1/0", strm_done, strm_busy);
    end
    @(negedge clk);
    #2;
    n_cmp++;
    if (strm_done !== 1'b0) begin
      n_bad++;
      $display("FAIL len0_pulse: done=%b, required 0", strm_done);
    end
    repeat (3) @(negedge clk);
    #2;
    n_cmp++;
    if (iss_n !== iss0) begin
      n_bad++;
      $display("FAIL len0_issue: %0d issues, required 0", iss_n - iss0);
    end
  endtask

`ifdef SRAM_CTRL_COLLISION_STALL_EN
  task automatic test_collision();
    clear_mon();
    strm_ready = 1'b1;
    @(negedge clk);
    strm_start = 1'b1;
    strm_base  = 9'h003;
    strm_len   = 10'd1;
    @(negedge clk);
    strm_start = 1'b0;
    req_valid  = 1'b1;
    req_we     = 1'b1;
    req_addr   = 9'h003;
    req_wdata  = 32'h5;
    req_wmask  = 4'hF;
    #2;
    n_cmp++;
    if (sram_csb1 !== 1'b1 || sram_csb0 !== 1'b0) begin
      n_bad++;
      $display("FAIL col_stall: csb1=%b csb0=%b, required 1/0", sram_csb1, sram_csb0);
    end
    @(negedge clk);
    req_valid = 1'b0;
    req_we    = 1'b0;
    #2;
    n_cmp++;
    if (sram_csb1 !== 1'b0 || sram_addr1 !== 9'h003) begin
      n_bad++;
      $display("FAIL col_retry: csb1=%b a1=%h, required 0/003", sram_csb1, sram_addr1);
    end
    repeat (6) @(negedge clk);
    #2;
    n_cmp++;
    if (got_d.size() !== 1 || got_d[0] !== 32'h5) begin
      n_bad++;
      $display("FAIL col_data: %0d words first %h, required 1 word 00000005",
               got_d.size(), (got_d.size() == 0) ? 32'h0 : got_d[0]);
    end
  endtask
`endif

  task automatic test_reset_mid();
    int rsp0;
    clear_mon();
    @(negedge clk);
    strm_start = 1'b1;
    strm_base  = 9'h000;
    strm_len   = 10'd8;
    strm_ready = 1'b0;
    req_valid  = 1'b1;
    req_we     = 1'b0;
    req_addr   = 9'h010;
    rsp_ready  = 1'b0;
    @(negedge clk);
    strm_start = 1'b0;
    req_valid  = 1'b0;
    repeat (2) @(negedge clk);
    rsp0 = rsp_n;
    rst  = 1'b1;
    #1;
    n_cmp++;
    if (strm_busy !== 1'b0 || strm_valid !== 1'b0 || strm_data !== 32'h0
        || sram_csb1 !== 1'b1 || strm_done !== 1'b0) begin
      n_bad++;
      $display("FAIL rm_strm: busy=%b valid=%b data=%h csb1=%b done=%b, required 0/0/0/1/0",
               strm_busy, strm_valid, strm_data, sram_csb1, strm_done);
    end
    n_cmp++;
    if (rsp_valid !== 1'b0 || rsp_rdata !== 32'h0 || req_ready !== 1'b0
        || sram_csb0 !== 1'b1) begin
      n_bad++;
      $display("FAIL rm_p0: valid=%b data=%h ready=%b csb0=%b, required 0/0/0/1",
               rsp_valid, rsp_rdata, req_ready, sram_csb0);
    end
    @(negedge clk);
    rst        = 1'b0;
    strm_ready = 1'b1;
    rsp_ready  = 1'b1;
    repeat (12) @(negedge clk);
    #2;
    n_cmp++;
    if (done_n !== 0 || rsp_n !== rsp0 || got_d.size() !== 0) begin
      n_bad++;
      $display("FAIL rm_ghost: done=%0d rsp=%0d words=%0d, required 0/0/0",
               done_n, rsp_n - rsp0, got_d.size());
    end
    n_cmp++;
    if (req_ready !== 1'b1 || strm_busy !== 1'b0) begin
      n_bad++;
      $display("FAIL rm_recover: ready=%b busy=%b, required 1/0", req_ready, strm_busy);
    end
  endtask

  initial begin
    rst        = 1'b1;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_wmask  = 4'h0;
    req_addr   = 9'h0;
    req_wdata  = 32'h0;
    rsp_ready  = 1'b1;
    strm_start = 1'b0;
    strm_base  = 9'h0;
    strm_len   = 10'd0;
    strm_ready = 1'b1;
    test_reset();
    test_write_read();
    test_mask();
    test_back_to_back();
    test_rsp_backpressure();
    test_stream_full();
    test_stream_toggle();
    test_len_zero();
`ifdef SRAM_CTRL_COLLISION_STALL_EN
    test_collision();
`endif
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
